// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and the operand-loader states.
package alu_pkg;

  localparam int unsigned DEFAULT_BUS_SIZE    = 8;
  localparam int unsigned DEFAULT_OPCODE_SIZE = 6;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    READY
  } loader_state_e;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Board-side bundle of the operand loader: raw switches/buttons in, ALU operands out.
interface alu_operand_loader_if #(
  parameter int unsigned BUS_SIZE    = alu_pkg::DEFAULT_BUS_SIZE,
  parameter int unsigned OPCODE_SIZE = alu_pkg::DEFAULT_OPCODE_SIZE
);

  logic [BUS_SIZE-1:0]    switches;
  logic                   btn_a;
  logic                   btn_b;
  logic                   btn_op;
  logic [BUS_SIZE-1:0]    num1;
  logic [BUS_SIZE-1:0]    num2;
  logic [OPCODE_SIZE-1:0] opcode;
  logic                   ready;
  logic                   seq_err;

  modport master (
    output switches, btn_a, btn_b, btn_op,
    input  num1, num2, opcode, ready, seq_err
  );

  modport slave (
    input  switches, btn_a, btn_b, btn_op,
    output num1, num2, opcode, ready, seq_err
  );

endinterface

// File: rtl/button_debouncer.sv
// Synchronises one raw push-button, debounces it and emits a registered one-cycle press pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            btn_meta_q;
  logic            btn_sync_q;
  logic            level_q;
  logic            level_prev_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      btn_meta_q   <= btn;
      btn_sync_q   <= btn_meta_q;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
      if (btn_sync_q != level_q) begin
        if (cnt_q == CntLast) begin
          level_q <= btn_sync_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// ALU front end: loads num1, num2 and opcode from the switches in button order A, B, opcode.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned BUS_SIZE        = DEFAULT_BUS_SIZE,
  parameter int unsigned OPCODE_SIZE     = DEFAULT_OPCODE_SIZE,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_operand_loader_if.slave bus
);

  logic [BUS_SIZE-1:0]    sw_meta_q;
  logic [BUS_SIZE-1:0]    sw_sync_q;
  logic                   press_a;
  logic                   press_b;
  logic                   press_op;
  loader_state_e          state_q;
  logic [BUS_SIZE-1:0]    num1_q;
  logic [BUS_SIZE-1:0]    num2_q;
  logic [OPCODE_SIZE-1:0] opcode_q;
  logic                   ready_q;
  logic                   seq_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= bus.switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_a (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_a),
    .press (press_a)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_b (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_b),
    .press (press_b)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_op (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_op),
    .press (press_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD_A;
      num1_q    <= '0;
      num2_q    <= '0;
      opcode_q  <= OPCODE_SIZE'(ADD);
      ready_q   <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      // An accepted load rewrites seq_err from any simultaneous stray press.
      unique case (state_q)
        LOAD_A: begin
          if (press_a) begin
            num1_q    <= sw_sync_q;
            state_q   <= LOAD_B;
            seq_err_q <= press_b | press_op;
          end else if (press_b | press_op) begin
            seq_err_q <= 1'b1;
          end
        end
        LOAD_B: begin
          if (press_b) begin
            num2_q    <= sw_sync_q;
            state_q   <= LOAD_OP;
            seq_err_q <= press_a | press_op;
          end else if (press_a | press_op) begin
            seq_err_q <= 1'b1;
          end
        end
        LOAD_OP: begin
          if (press_op) begin
            opcode_q  <= sw_sync_q[OPCODE_SIZE-1:0];
            state_q   <= READY;
            ready_q   <= 1'b1;
            seq_err_q <= press_a | press_b;
          end else if (press_a | press_b) begin
            seq_err_q <= 1'b1;
          end
        end
        READY: begin
          if (press_a)  num1_q   <= sw_sync_q;
          if (press_b)  num2_q   <= sw_sync_q;
          if (press_op) opcode_q <= sw_sync_q[OPCODE_SIZE-1:0];
        end
        default: begin
          state_q <= LOAD_A;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.num1    = num1_q;
  assign bus.num2    = num2_q;
  assign bus.opcode  = opcode_q;
  assign bus.ready   = ready_q;
  assign bus.seq_err = seq_err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;

  localparam int unsigned Dbnc = 4;
  localparam logic [23:0] RstV = {8'h00, 8'h00, 6'b100000, 1'b0, 1'b0};

  typedef struct {
    logic [23:0] val;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_go   = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_operand_loader_if #(.BUS_SIZE(8), .OPCODE_SIZE(6)) bus ();

  alu_operand_loader #(
    .BUS_SIZE        (8),
    .OPCODE_SIZE     (6),
    .DEBOUNCE_CYCLES (Dbnc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [23:0] snap(input logic [7:0] n1, input logic [7:0] n2,
                                       input logic [5:0] op, input logic rdy, input logic err);
    return {n1, n2, op, rdy, err};
  endfunction

  function automatic logic [23:0] obs_now();
    return {bus.num1, bus.num2, bus.opcode, bus.ready, bus.seq_err};
  endfunction

  task automatic expect_at(input logic [23:0] v, input int c);
    sb_q.push_back('{val: v, cyc: c});
  endtask

  task automatic check_pop(input logic [23:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_change @cyc %0d: got %h, required no change", cyc, obs);
      return;
    end
    e = sb_q.pop_front();
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL outputs @cyc %0d: got %h required %h", cyc, obs, e.val);
    end
    if (e.cyc >= 0) begin
      n_checks++;
      if (cyc != e.cyc) begin
        n_fail++;
        $display("FAIL load_cycle: got %0d required %0d", cyc, e.cyc);
      end
    end
  endtask

  // Every output change (or reset assertion) must match the next scoreboard entry.
  initial begin : monitor
    logic [23:0] prev;
    logic [23:0] cur;
    logic        in_rst;
    in_rst = 1'b0;
    wait (mon_go);
    prev = obs_now();
    check_pop(prev);
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          #1;
          prev = obs_now();
          check_pop(prev);
        end
      end else begin
        in_rst = 1'b0;
        cur = obs_now();
        if (cur !== prev) begin
          check_pop(cur);
          prev = cur;
        end
      end
    end
  end

  task automatic drive_btn(input logic [2:0] m);
    bus.btn_a  = m[0];
    bus.btn_b  = m[1];
    bus.btn_op = m[2];
  endtask

  // Button(s) high for 'hold' cycles; load expected 8 edges after the driving negedge.
  task automatic press(input logic [2:0] m, input logic [7:0] sw, input int hold,
                       input logic [23:0] exp_v);
    @(negedge clk);
    bus.switches = sw;
    drive_btn(m);
    expect_at(exp_v, cyc + 8);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (i == 12) bus.switches = ~sw;
    end
    @(negedge clk);
    drive_btn(3'b000);
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3;
    expect_at(RstV, -1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    bus.switches = 8'h00;
    drive_btn(3'b000);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_at(RstV, -1);
    mon_go = 1'b1;
    repeat (2) @(negedge clk);

    // Ordered load A, B, opcode.
    press(3'b001, 8'h3C, 10, snap(8'h3C, 8'h00, 6'b100000, 1'b0, 1'b0));
    press(3'b010, 8'h05, 10, snap(8'h3C, 8'h05, 6'b100000, 1'b0, 1'b0));
    press(3'b100, 8'h22, 10, snap(8'h3C, 8'h05, 6'b100010, 1'b1, 1'b0));

    // READY: simultaneous reload, then a long hold with switches changing mid-hold.
    press(3'b011, 8'hFF, 10, snap(8'hFF, 8'hFF, 6'b100010, 1'b1, 1'b0));
    press(3'b001, 8'h11, 30, snap(8'h11, 8'hFF, 6'b100010, 1'b1, 1'b0));

    pulse_reset();
    repeat (2) @(negedge clk);

    // Out-of-order opcode press in LOAD_A.
    press(3'b100, 8'h07, 10, snap(8'h00, 8'h00, 6'b100000, 1'b0, 1'b1));

    // Bounce on btn_a, then a clean hold that also clears seq_err.
    @(negedge clk);
    bus.switches = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      drive_btn(3'b001);
      repeat (3) @(negedge clk);
      drive_btn(3'b000);
      @(negedge clk);
    end
    drive_btn(3'b001);
    expect_at(snap(8'h5A, 8'h00, 6'b100000, 1'b0, 1'b0), cyc + 8);
    repeat (10) @(negedge clk);
    drive_btn(3'b000);
    repeat (12) @(negedge clk);

    // Reset two cycles into a press; the still-held button is debounced afresh.
    @(negedge clk);
    bus.switches = 8'h99;
    drive_btn(3'b001);
    repeat (2) @(negedge clk);
    #3;
    expect_at(RstV, -1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_at(snap(8'h99, 8'h00, 6'b100000, 1'b0, 1'b0), cyc + 8);
    repeat (10) @(negedge clk);
    drive_btn(3'b000);
    repeat (12) @(negedge clk);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end stage for the 8-bit FPGA ALU. It turns board switches and three push-buttons into the registered `num1`, `num2` and `opcode` operands the ALU consumes. Raw button inputs are synchronised, debounced and edge-detected, and a small FSM enforces the load order A → B → opcode before flagging the operands as ready. Its outputs wire directly to the ALU's operand and opcode inputs.

## Interface
- `BUS_SIZE`, default 8: operand and switch width.
- `OPCODE_SIZE`, default 6: opcode width. Must be ≤ `BUS_SIZE`.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level change. Must be ≥ 1.
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `switches`, input, `BUS_SIZE`: raw board switches, asynchronous to `clk`.
- `btn_a`, `btn_b`, `btn_op`, input, 1 each: raw push-buttons, active-high, asynchronous.
- `num1`, output, `BUS_SIZE`: registered operand A.
- `num2`, output, `BUS_SIZE`: registered operand B.
- `opcode`, output, `OPCODE_SIZE`: registered opcode.
- `ready`, output, 1: high once A, B and opcode have all been loaded in order.
- `seq_err`, output, 1: sticky flag for an out-of-order button press.

## Operation
- **Synchronisers.** `switches` and each button pass through a 2-flop synchroniser.
- **Debounce, per button.**
  - The debounced level changes only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle of agreement clears the counter.
  - A 0→1 transition of the debounced level produces a one-cycle `press` pulse. The 1→0 transition produces no pulse.
- **Load values.** A press loads the synchronised switch value present in the same cycle as the pulse. `num1` and `num2` take the full bus. `opcode` takes `switches[OPCODE_SIZE-1:0]`.
- **FSM states:** LOAD_A, LOAD_B, LOAD_OP, READY.
  - LOAD_A: `press_a` loads `num1` and moves to LOAD_B.
  - LOAD_B: `press_b` loads `num2` and moves to LOAD_OP.
  - LOAD_OP: `press_op` loads `opcode` and moves to READY.
  - In any LOAD state, a press of a non-expected button is ignored (no register change, no state change) and sets `seq_err`.
  - When the expected press and an unexpected press occur in the same cycle, the expected load happens and `seq_err` is set.
  - `seq_err` clears on the next accepted load.
  - READY: every pulsed button reloads its register. Simultaneous presses all load in the same cycle. The FSM stays in READY, `seq_err` stays 0, and there is no way back to LOAD_A except reset.
- **`ready`** is asserted exactly when state == READY.
- **Reset values:**
  - `num1` = 0, `num2` = 0.
  - `opcode` = ADD (6'b100000).
  - `ready` = 0, `seq_err` = 0, state LOAD_A.
  - Debounced levels 0, counters 0, synchroniser flops 0.
- **Reset during a press.** Asserting `rst_n` low mid-press aborts it. If the button is still held after release of reset, it is debounced afresh and produces a press once it satisfies the debounce rule.

## Timing
- All outputs are registered and change only on `clk` rising edges, or asynchronously on reset.
- **Press latency.** With the button held high from the first edge E that samples it high, the debounced level rises at edge E+1+`DEBOUNCE_CYCLES`. The `press` pulse is high in the following cycle, and the target register and state update at edge E+`DEBOUNCE_CYCLES`+3.
- **Glitches.** A bounce shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- **Holding a button.** A held button produces exactly one pulse. A new pulse requires release (debounced 0) and then a fresh press.
- **Switch changes.** Changing switches while a button is held has no effect after the load edge.

## Structure
- **Package `alu_pkg`:**
  - `BUS_SIZE` and `OPCODE_SIZE` defaults.
  - The opcode constants ADD, SUB, AND, OR, XOR, NOR, SRL, SRA.
  - The loader state enum `{LOAD_A, LOAD_B, LOAD_OP, READY}`.
  - The ALU imports the same opcode constants.
- **Sub-module `button_debouncer`:** 2-flop synchroniser, stability counter of width `$clog2(DEBOUNCE_CYCLES+1)` and rising-edge pulse. It is instantiated three times.
- **Top level:** contains the switch synchroniser, the FSM and the operand registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset.** Hold `rst_n` low mid-simulation → `num1`=0, `num2`=0, `opcode`=6'b100000, `ready`=0, `seq_err`=0, all asynchronously with no clock edge required.
- **Ordered load.** switches=8'h3C with `btn_a` held 10 cycles, then 8'h05 with `btn_b`, then 8'h22 with `btn_op` → `num1`=8'h3C at edge E+7, then `num2`=8'h05, then `opcode`=6'b100010 and `ready`=1.
- **Bounce rejection.** Toggle `btn_a` high 3 cycles / low 1 cycle, four times, then hold it high → exactly one load, occurring 7 edges after the final rising sample.
- **Out-of-order press.** In LOAD_A press `btn_op` → `seq_err`=1 and `opcode` unchanged. Then press `btn_a` → `num1` loads and `seq_err`=0.
- **READY reload.** In READY press `btn_a` and `btn_b` together with switches=8'hFF → `num1`=`num2`=8'hFF on the same edge, `ready` stays 1. A held button yields only one load.
- **Reset mid-debounce.** Assert `rst_n` 2 cycles into a `btn_a` press → no load. Release reset with the button still held → load 7 edges after the first post-reset sample.
